// File: rtl/vga_sync_out.sv
// vga_sync_out: 640x480@60 VGA timing generator and registered TinyVGA PMOD output stage.
// Ports: clk pixel clock; rst_n sync active-low reset; rgb_in {R1,R0,G1,G0,B1,B0} colour for
// current hpos/vpos; test_sel picks the built-in bar pattern (only with PONG_TESTPATTERN_EN);
// hpos/vpos beam counters; display_on visible region; frame_tick one-cycle strobe at start of
// vertical blank; uo_out {hsync,B0,G0,R0,vsync,B1,G1,R1} registered one cycle after the counters.
// Optional feature macro: PONG_TESTPATTERN_EN.
module vga_sync_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] rgb_in,
  input  logic       test_sel,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       frame_tick,
  output logic [7:0] uo_out
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h, v;
  logic       hs, vs;
  logic [5:0] src, c;
  assign hpos       = h;
  assign vpos       = v;
  assign display_on = h < H_VIS && v < V_VIS;
  // gated by rst_n so no strobe escapes while the counters are being cleared
  assign frame_tick = rst_n && h == 10'd0 && v == V_VIS;
  assign hs         = !(h >= HS_ON && h < HS_OFF);
  assign vs         = !(v >= VS_ON && v < VS_OFF);
`ifdef PONG_TESTPATTERN_EN
  logic [2:0] bar;
  assign bar = h[8:6];
  assign src = test_sel ? {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]} : rgb_in;
`else
  logic unused_test_sel;
  assign unused_test_sel = test_sel;
  assign src = rgb_in;
`endif
  assign c = display_on ? src : 6'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h      <= 10'd0;
      v      <= 10'd0;
      uo_out <= 8'h88;
    end else begin
      h      <= h == H_LAST ? 10'd0 : h + 10'd1;
      v      <= h != H_LAST ? v : v == V_LAST ? 10'd0 : v + 10'd1;
      uo_out <= {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    end
  end
endmodule
